// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory fetch bus between if_stage and imem
// Signals:
//   imem_req   fetch request (master -> slave)
//   imem_addr  fetch byte address, stable while imem_req=1 (master -> slave)
//   imem_ready request completes this cycle (slave -> master)
//   imem_rdata fetched instruction word, valid with imem_ready (slave -> master)
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   imem          fetch bus (master side): req/addr out, ready/rdata in
//   stall         hazard unit: hold PC and IF/ID
//   branch_taken  decode resolved a taken branch
//   Branch_Addr   branch target from decode
//   IFtoID_PC     PC+4 of the instruction held in IF/ID
//   IFtoID_inst   instruction held in IF/ID
//   IFtoID_valid  IF/ID holds a real instruction (0 = bubble)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  imem,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] Branch_Addr,
    output logic [31:0] IFtoID_PC,
    output logic [31:0] IFtoID_inst,
    output logic        IFtoID_valid
);

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_HELD     = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_req;
    logic [31:0] r_skid;
    logic [31:0] r_redirect;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_inst;
    logic        r_ifid_valid;

    logic        w_comp;
    logic [31:0] w_pc_plus4;

    // A completion needs our own request; ready without a request is ignored.
    assign w_comp     = r_req & imem.imem_ready;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;

    assign IFtoID_PC    = r_ifid_pc;
    assign IFtoID_inst  = r_ifid_inst;
    assign IFtoID_valid = r_ifid_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_req        <= 1'b0;
            r_skid       <= 32'h0;
            r_redirect   <= 32'h0;
            r_ifid_pc    <= 32'h0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end

                ST_FETCH: begin
                    if (stall) begin
                        // Park a completed word so the memory is not asked twice.
                        if (w_comp) begin
                            r_skid  <= imem.imem_rdata;
                            r_state <= ST_HELD;
                            r_req   <= 1'b0;
                        end
                    end else if (branch_taken) begin
                        r_ifid_pc    <= 32'h0;
                        r_ifid_inst  <= NOP_INST;
                        r_ifid_valid <= 1'b0;
                        if (w_comp) begin
                            r_pc <= Branch_Addr;
                        end else begin
                            // The request at the old PC must still finish before
                            // the address may move to the target.
                            r_redirect <= Branch_Addr;
                            r_state    <= ST_REDIRECT;
                        end
                    end else if (w_comp) begin
                        r_ifid_pc    <= w_pc_plus4;
                        r_ifid_inst  <= imem.imem_rdata;
                        r_ifid_valid <= 1'b1;
                        r_pc         <= w_pc_plus4;
                    end else begin
                        r_ifid_pc    <= 32'h0;
                        r_ifid_inst  <= NOP_INST;
                        r_ifid_valid <= 1'b0;
                    end
                end

                ST_HELD: begin
                    if (!stall) begin
                        if (branch_taken) begin
                            r_ifid_pc    <= 32'h0;
                            r_ifid_inst  <= NOP_INST;
                            r_ifid_valid <= 1'b0;
                            r_pc         <= Branch_Addr;
                        end else begin
                            r_ifid_pc    <= w_pc_plus4;
                            r_ifid_inst  <= r_skid;
                            r_ifid_valid <= 1'b1;
                            r_pc         <= w_pc_plus4;
                        end
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end
                end

                ST_REDIRECT: begin
                    // Decode only sees bubbles here, so stall/branch are moot.
                    r_ifid_pc    <= 32'h0;
                    r_ifid_inst  <= NOP_INST;
                    r_ifid_valid <= 1'b0;
                    if (w_comp) begin
                        r_pc    <= r_redirect;
                        r_state <= ST_FETCH;
                    end
                end

                default: begin
                    r_state <= ST_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] Branch_Addr;
    logic [31:0] IFtoID_PC;
    logic [31:0] IFtoID_inst;
    logic        IFtoID_valid;
    logic        r_ready;

    int n_vec;
    int n_err;

    if_stage_if imem_bus ();

    assign imem_bus.imem_ready = r_ready;
    assign imem_bus.imem_rdata = imem_bus.imem_addr ^ KEY;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem_bus),
        .stall        (stall),
        .branch_taken (branch_taken),
        .Branch_Addr  (Branch_Addr),
        .IFtoID_PC    (IFtoID_PC),
        .IFtoID_inst  (IFtoID_inst),
        .IFtoID_valid (IFtoID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] pc, input logic [31:0] inst,
                            input logic valid);
        chk({name, ".pc"}, IFtoID_PC, pc);
        chk({name, ".inst"}, IFtoID_inst, inst);
        chk({name, ".valid"}, {31'h0, IFtoID_valid}, {31'h0, valid});
    endtask

    // Reset, release, BOOT cycle; leaves the DUT in FETCH at pc=0.
    task automatic restart();
        stall = 0; branch_taken = 0; Branch_Addr = 0; r_ready = 0;
        rst = 0;
        tick();
        rst = 1;
        tick();
    endtask

    // Completes n fetches back to back starting in FETCH.
    task automatic run_fetches(input int n);
        r_ready = 1;
        for (int i = 0; i < n; i++) tick();
        r_ready = 0;
    endtask

    task automatic test_reset();
        stall = 0; branch_taken = 0; Branch_Addr = 0; r_ready = 1;
        rst = 0;
        tick();
        chk("reset.req", {31'h0, imem_bus.imem_req}, 32'h0);
        chk("reset.addr", imem_bus.imem_addr, 32'h0);
        chk_ifid("reset.ifid", 32'h0, 32'h0, 1'b0);
        rst = 1;
        tick();
        chk("boot.req", {31'h0, imem_bus.imem_req}, 32'h1);
        chk("boot.valid", {31'h0, IFtoID_valid}, 32'h0);
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        pc = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_ifid("stream", pc + 32'd4, pc ^ KEY, 1'b1);
            pc = pc + 32'd4;
            chk("stream.addr", imem_bus.imem_addr, pc);
        end
        // Asynchronous reset between edges.
        #2;
        rst = 0;
        #1;
        chk("areset.req", {31'h0, imem_bus.imem_req}, 32'h0);
        chk("areset.addr", imem_bus.imem_addr, 32'h0);
        chk_ifid("areset.ifid", 32'h0, 32'h0, 1'b0);
        r_ready = 0;
    endtask

    task automatic test_slow();
        logic [31:0] pc;
        restart();
        pc = 32'h0;
        for (int i = 0; i < 12; i++) begin
            r_ready = (i % 3 == 2);
            tick();
            if (i % 3 == 2) begin
                chk_ifid("slow.done", pc + 32'd4, pc ^ KEY, 1'b1);
                pc = pc + 32'd4;
            end else begin
                chk("slow.bubble", {31'h0, IFtoID_valid}, 32'h0);
            end
            chk("slow.addr", imem_bus.imem_addr, pc);
            chk("slow.req", {31'h0, imem_bus.imem_req}, 32'h1);
        end
        r_ready = 0;
    endtask

    task automatic test_stall();
        restart();
        run_fetches(4);
        chk("stall.pre_addr", imem_bus.imem_addr, 32'h10);
        stall = 1; r_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ifid("stall.frozen", 32'h10, 32'hC ^ KEY, 1'b1);
            chk("stall.req", {31'h0, imem_bus.imem_req}, 32'h0);
            chk("stall.addr", imem_bus.imem_addr, 32'h10);
        end
        stall = 0; r_ready = 0;
        tick();
        chk_ifid("stall.release", 32'h14, 32'h10 ^ KEY, 1'b1);
        chk("stall.next_addr", imem_bus.imem_addr, 32'h14);
        chk("stall.next_req", {31'h0, imem_bus.imem_req}, 32'h1);
        r_ready = 1;
        tick();
        chk_ifid("stall.after", 32'h18, 32'h14 ^ KEY, 1'b1);
        r_ready = 0;
    endtask

    task automatic test_branch_outstanding();
        restart();
        run_fetches(8);
        chk("br.pre_addr", imem_bus.imem_addr, 32'h20);
        branch_taken = 1; Branch_Addr = 32'h100;
        tick();
        branch_taken = 0; Branch_Addr = 32'h0;
        chk_ifid("br.flush", 32'h0, 32'h0, 1'b0);
        chk("br.stale_addr", imem_bus.imem_addr, 32'h20);
        chk("br.stale_req", {31'h0, imem_bus.imem_req}, 32'h1);
        tick();
        chk("br.wait_addr", imem_bus.imem_addr, 32'h20);
        chk("br.wait_valid", {31'h0, IFtoID_valid}, 32'h0);
        r_ready = 1;
        tick();
        chk("br.target_addr", imem_bus.imem_addr, 32'h100);
        chk("br.drop_valid", {31'h0, IFtoID_valid}, 32'h0);
        tick();
        chk_ifid("br.first", 32'h104, 32'h100 ^ KEY, 1'b1);
        r_ready = 0;
    endtask

    task automatic test_branch_stall_held();
        // Continues from pc=0x104 in FETCH, IF/ID = {0x104, word@0x100, 1}.
        stall = 1; branch_taken = 1; Branch_Addr = 32'h200; r_ready = 0;
        tick();
        chk("bs.addr", imem_bus.imem_addr, 32'h104);
        chk_ifid("bs.hold", 32'h104, 32'h100 ^ KEY, 1'b1);
        branch_taken = 0; r_ready = 1;
        tick();
        chk("held.req", {31'h0, imem_bus.imem_req}, 32'h0);
        stall = 0; branch_taken = 1; Branch_Addr = 32'h300; r_ready = 0;
        tick();
        branch_taken = 0;
        chk("held.br_addr", imem_bus.imem_addr, 32'h300);
        chk_ifid("held.flush", 32'h0, 32'h0, 1'b0);
        r_ready = 1;
        tick();
        chk_ifid("held.resume", 32'h304, 32'h300 ^ KEY, 1'b1);
        r_ready = 0;
    endtask

    task automatic test_wrap();
        // Branch with completion in FETCH redirects immediately.
        branch_taken = 1; Branch_Addr = 32'hFFFF_FFFC; r_ready = 1;
        tick();
        branch_taken = 0;
        chk("wrap.addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap.flush", {31'h0, IFtoID_valid}, 32'h0);
        tick();
        chk_ifid("wrap.ifid", 32'h0, 32'h5A5A_FFFC, 1'b1);
        chk("wrap.next_addr", imem_bus.imem_addr, 32'h0);
        r_ready = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_slow();
        test_stall();
        test_branch_outstanding();
        test_branch_stall_held();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
